// File: rtl/game_step_scheduler.sv
// game_step_scheduler
//   Sequences the game datapath during play: turns raw direction keys into a
//   one-cycle key_press pulse plus a reversal-protected heading, paces move
//   requests on a frame-counted step tick with a req/ack handshake, and
//   shortens the step period as food is eaten.
//
// Ports
//   vga_clk          in   pixel/system clock
//   sys_rst_n        in   asynchronous, active-low reset
//   state[1:0]       in   game state (Gray): 00 START, 01 IN_GAME, 11 WON, 10 OVER
//   frame_start      in   one-cycle pulse per video frame
//   key_up/down/left/right in  synchronous key levels, active-high
//   food_eaten       in   one-cycle pulse from the datapath
//   move_ack         in   datapath accepts the current move
//   move_req         out  move request (held until acked)
//   move_dir[1:0]    out  heading of the request: 00 up, 01 right, 10 down, 11 left
//   key_press        out  one-cycle pulse on any key rising edge
//   level[3:0]       out  current speed level (saturates at 15)
//   frames_per_step[5:0] out  active step period in frames
//   step_overrun     out  sticky: a step tick arrived while a request was pending
module game_step_scheduler #(
   parameter int FPS_INIT      = 30,
   parameter int FPS_MIN       = 6,
   parameter int FPS_DEC       = 2,
   parameter int SPEEDUP_EVERY = 4
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic [1:0] state,
   input  logic       frame_start,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       food_eaten,
   input  logic       move_ack,
   output logic       move_req,
   output logic [1:0] move_dir,
   output logic       key_press,
   output logic [3:0] level,
   output logic [5:0] frames_per_step,
   output logic       step_overrun
);

   localparam logic [1:0] GS_START   = 2'b00;
   localparam logic [1:0] GS_IN_GAME = 2'b01;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   localparam logic [5:0] C_FPS_INIT  = 6'(FPS_INIT);
   localparam logic [5:0] C_FPS_MIN   = 6'(FPS_MIN);
   localparam logic [5:0] C_FPS_DEC   = 6'(FPS_DEC);
   localparam logic [6:0] C_DEC_FLOOR = 7'(FPS_MIN + FPS_DEC);
   localparam logic [3:0] C_FOOD_LAST = 4'(SPEEDUP_EVERY - 1);

   logic [3:0] r_key_q;
   logic       r_key_press;
   logic [1:0] r_pending_dir;
   logic [1:0] r_move_dir;
   logic [0:0] r_state;
   logic       r_overrun;
   logic [5:0] r_frame_cnt;
   logic [3:0] r_food_cnt;
   logic [3:0] r_level;
   logic [5:0] r_fps;

   logic [3:0] w_keys;
   logic [3:0] w_rise;
   logic       w_in_game;
   logic       w_start;
   logic [1:0] w_cand;
   logic       w_cand_ok;
   logic [6:0] w_cnt_plus1;
   logic       w_tick;
   logic       w_food_full;
   logic [5:0] w_fps_dec;

   // bit 3 = up ... bit 0 = right, so a priority scan from the top gives up > down > left > right
   assign w_keys      = {key_up, key_down, key_left, key_right};
   assign w_rise      = w_keys & ~r_key_q;
   assign w_in_game   = (state == GS_IN_GAME);
   assign w_start     = (state == GS_START);

   always_comb begin
      w_cand = DIR_RIGHT;
      if (w_rise[3])      w_cand = DIR_UP;
      else if (w_rise[2]) w_cand = DIR_DOWN;
      else if (w_rise[1]) w_cand = DIR_LEFT;
      else                w_cand = DIR_RIGHT;
   end

   // Reversal is judged against the heading actually committed to the datapath,
   // not against the pending one, so two quick turns can still reach "behind".
   assign w_cand_ok   = (|w_rise) && ((w_cand ^ r_move_dir) != 2'b10);

   // ">=" rather than "==" so that a period shortened below the current count
   // still fires on the very next frame instead of wrapping.
   assign w_cnt_plus1 = {1'b0, r_frame_cnt} + 7'd1;
   assign w_tick      = w_in_game && frame_start && (w_cnt_plus1 >= {1'b0, r_fps});

   assign w_food_full = (r_food_cnt >= C_FOOD_LAST);
   assign w_fps_dec   = ({1'b0, r_fps} >= C_DEC_FLOOR) ? (r_fps - C_FPS_DEC) : C_FPS_MIN;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_key_q       <= 4'd0;
         r_key_press   <= 1'b0;
         r_pending_dir <= DIR_RIGHT;
         r_move_dir    <= DIR_RIGHT;
         r_state       <= ST_IDLE;
         r_overrun     <= 1'b0;
         r_frame_cnt   <= 6'd0;
         r_food_cnt    <= 4'd0;
         r_level       <= 4'd0;
         r_fps         <= C_FPS_INIT;
      end else begin
         r_key_q     <= w_keys;
         r_key_press <= |w_rise;

         if (w_start) begin
            r_pending_dir <= DIR_RIGHT;
            r_move_dir    <= DIR_RIGHT;
            r_state       <= ST_IDLE;
            r_overrun     <= 1'b0;
            r_frame_cnt   <= 6'd0;
            r_food_cnt    <= 4'd0;
            r_level       <= 4'd0;
            r_fps         <= C_FPS_INIT;
         end else if (w_in_game) begin
            if (frame_start)
               r_frame_cnt <= w_tick ? 6'd0 : w_cnt_plus1[5:0];

            // The tick above already compared against the old period; the new
            // period only matters from the next frame onward.
            if (food_eaten) begin
               if (w_food_full) begin
                  r_food_cnt <= 4'd0;
                  if (r_level != 4'd15)
                     r_level <= r_level + 4'd1;
                  r_fps <= w_fps_dec;
               end else begin
                  r_food_cnt <= r_food_cnt + 4'd1;
               end
            end

            if (w_cand_ok)
               r_pending_dir <= w_cand;

            case (r_state)
               ST_IDLE: begin
                  if (w_tick) begin
                     r_state    <= ST_REQ;
                     r_move_dir <= r_pending_dir;
                  end
               end
               default: begin
                  if (w_tick)
                     r_overrun <= 1'b1;
                  if (move_ack)
                     r_state <= ST_IDLE;
               end
            endcase
         end else begin
            // WON / OVER: freeze everything except abort any outstanding request.
            r_frame_cnt <= 6'd0;
            r_state     <= ST_IDLE;
         end
      end
   end

   assign move_req        = (r_state == ST_REQ);
   assign move_dir        = r_move_dir;
   assign key_press       = r_key_press;
   assign level           = r_level;
   assign frames_per_step = r_fps;
   assign step_overrun    = r_overrun;

endmodule

// File: doc/game_step_scheduler.md
Name: game_step_scheduler

Overview:
- Sequences the game datapath during play. Converts raw direction keys into a one-cycle key_press pulse for the game-state FSM and a latched, reversal-protected heading.
- Issues paced move requests to the game-logic datapath on a frame-based tick, with a req/ack handshake.
- Raises game speed as food is eaten.

Parameters:
FPS_INIT, 30, frames between steps at level 0 (range 2..63)
FPS_MIN, 6, fastest allowed frames-per-step (2..FPS_INIT)
FPS_DEC, 2, frames removed from the step period per level-up
SPEEDUP_EVERY, 4, food events per level-up (1..15)

Ports:
vga_clk  in  1  pixel/system clock
sys_rst_n  in  1  asynchronous, active-low reset
state  in  2  game state, Gray-coded: 00 START, 01 IN_GAME, 11 WON, 10 OVER
frame_start  in  1  one-cycle pulse per video frame
key_up, key_down, key_left, key_right  in  1 each  synchronous key levels, active-high
food_eaten  in  1  one-cycle pulse from datapath
move_ack  in  1  datapath accepts current move
move_req  out  1  move request
move_dir  out  2  heading of request: 00 up, 01 right, 10 down, 11 left
key_press  out  1  one-cycle pulse on any key rising edge
level  out  4  current speed level
frames_per_step  out  6  active step period
step_overrun  out  1  sticky: a step tick was dropped

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; the clock is vga_clk. Reset values: move_req=0, move_dir=01, key_press=0, level=0, frames_per_step=FPS_INIT, step_overrun=0. Internal frame count, food count and pending_dir also reset (pending_dir=01).
- Key edge detect:
  - Each key is registered once.
  - rise = key & ~key_q.
  - key_press = registered OR of the four rises. It is high exactly one cycle, 1 cycle after the rising edge.
  - key_press is generated in every state.
- Heading:
  - Updated only when state=IN_GAME, on a key rise.
  - Priority when several keys rise together: up > down > left > right.
  - A candidate that is the opposite of the last committed move_dir is ignored. Opposite means XOR = 2'b10.
  - The later rise wins within a step period.
- Step tick:
  - In IN_GAME, frame_start increments the frame count.
  - When frame_start arrives with count = frames_per_step-1, the count clears to 0 and a tick fires.
  - Outside IN_GAME the count holds at 0.
- Handshake FSM, two states IDLE/REQ:
  - IDLE, tick: go to REQ. move_req=1 and move_dir=pending_dir on the next edge.
  - REQ: move_req and move_dir stay stable until move_ack=1 is sampled. move_req is then low on the following edge and the FSM returns to IDLE.
  - A tick while in REQ is dropped and step_overrun is set. step_overrun clears only on reset or on entry to START.
  - move_ack while in IDLE is ignored.
- Abort: if state≠IN_GAME while in REQ, the FSM goes to IDLE and move_req=0 on the next edge without waiting for ack.
- Speed-up:
  - In IN_GAME, each food_eaten increments the food count.
  - When the count reaches SPEEDUP_EVERY, it clears, level increments (saturating at 15), and frames_per_step = max(FPS_MIN, frames_per_step-FPS_DEC). Use unsigned compare; no underflow.
- Simultaneous food_eaten and tick: both take effect. The new period applies from the next count comparison.
- If frames_per_step drops below count+1, the tick fires on the next frame_start and the count clears.
- state=START: level, frames_per_step, food count, frame count, step_overrun and pending_dir/move_dir (=01) return to reset values every cycle.
- WON/OVER: all values hold, no ticks.

Test Plan:
- Reset, state=01, 30 frame_start pulses, ack 2 cycles after req → move_req rises 1 cycle after 30th pulse with move_dir=01, falls 1 cycle after ack; no overrun.
- Heading at move_dir=01: key_left then key_up rise in one period → left ignored, next req carries 00; key_up and key_right rising same cycle → 00.
- key_down rise in state=00 → key_press high exactly 1 cycle; pending_dir unchanged.
- 8 food_eaten pulses in IN_GAME → level=2, frames_per_step=26; 60 further pulses → level stays 15, frames_per_step=6.
- Hold move_ack=0 across two ticks → second tick dropped, step_overrun=1, move_req stays high with the original move_dir.
- move_req high, state→10 → move_req=0 next cycle, FSM idle; state→00 → level=0, frames_per_step=30, step_overrun=0.
